beam_delay_align_rt: RTL and testbench

// - Next-generation beam aligner. Delays each of NCHAN sample streams per beam, at sample

---
 rtl/beam_delay_align_rt.sv | 122 ++++++++++++
 tb/tb_beam_delay_align_rt.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_delay_align_rt.sv
// Per-(beam,channel) sample-granular delay aligner with a shadow/active delay table.
// Each output lane is picked by a mux on the active delay from a window of recent samples.

module beam_delay_align_sel #(
  parameter int NBITS = 5,
  parameter int NSAMP = 8,
  parameter int WN    = 80,
  parameter int IW    = 7,
  parameter int DW    = 7
) (
  input  logic [WN-1:0][NBITS-1:0] win_i,
  input  logic [DW-1:0]            d_i,
  output logic [NSAMP*NBITS-1:0]   smp_o
);
  // win_i[0] is the newest sample, so lane s at delay d sits at NSAMP-1-s+d
  for (genvar s = 0; s < NSAMP; s++) begin : g_lane
    logic [IW-1:0] idx;
    assign idx = IW'(NSAMP-1-s) + IW'(d_i);
    assign smp_o[s*NBITS +: NBITS] = win_i[idx];
  end
endmodule

module beam_delay_align_rt #(
  parameter int NBITS     = 5,
  parameter int NSAMP     = 8,
  parameter int NCHAN     = 8,
  parameter int NBEAMS    = 2,
  parameter int MAX_DELAY = 72,
  localparam int DW    = $clog2(MAX_DELAY+1),
  localparam int DEPTH = (MAX_DELAY+NSAMP-1)/NSAMP+1,
  localparam int BW    = (NBEAMS > 1) ? $clog2(NBEAMS) : 1,
  localparam int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NCHAN-1:0][NSAMP*NBITS-1:0]         data_i,
  input  logic                                      wr_en_i,
  input  logic [BW-1:0]                             wr_beam_i,
  input  logic [CW-1:0]                             wr_chan_i,
  input  logic [DW-1:0]                             wr_delay_i,
  input  logic                                      update_i,
  input  logic                                      err_clr_i,
  output logic [NBEAMS-1:0][NCHAN-1:0][NSAMP*NBITS-1:0] beams_o,
  output logic                                      valid_o,
  output logic                                      update_ack_o,
  output logic                                      err_o
);
  localparam int SW = NSAMP*NBITS;
  localparam int WN = DEPTH*NSAMP;
  localparam int IW = $clog2(WN);
  localparam int FW = $clog2(DEPTH+1);
  localparam logic [NBITS-1:0] MID = NBITS'(1 << (NBITS-1));

  logic [NCHAN-1:0][DEPTH-2:0][SW-1:0]      hist_q;
  logic [NCHAN-1:0][WN-1:0][NBITS-1:0]      win;
  logic [NBEAMS-1:0][NCHAN-1:0][DW-1:0]     shadow_q, active_q;
  logic [NBEAMS-1:0][NCHAN-1:0][SW-1:0]     sel, beams_q;
  logic [FW-1:0]                            fill_q, fill_d;
  logic                                     ack_q, err_q, err_d;
  logic                                     wr_oor, wr_clamp;
  logic [DW-1:0]                            wr_val;

  // Window = current input clock followed by DEPTH-1 previous clocks, newest sample first
  always_comb begin
    win = '0;
    for (int c = 0; c < NCHAN; c++) begin
      for (int j = 0; j < NSAMP; j++) begin
        win[c][j] = data_i[c][(NSAMP-1-j)*NBITS +: NBITS];
        for (int h = 0; h < DEPTH-1; h++)
          win[c][(h+1)*NSAMP+j] = hist_q[c][h][(NSAMP-1-j)*NBITS +: NBITS];
      end
    end
  end

  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
      beam_delay_align_sel #(
        .NBITS(NBITS), .NSAMP(NSAMP), .WN(WN), .IW(IW), .DW(DW)
      ) u_sel (
        .win_i (win[c]),
        .d_i   (active_q[b][c]),
        .smp_o (sel[b][c])
      );
    end
  end

  assign wr_oor   = (int'(wr_beam_i) >= NBEAMS) || (int'(wr_chan_i) >= NCHAN);
  assign wr_clamp = wr_delay_i > DW'(MAX_DELAY);
  assign wr_val   = wr_clamp ? DW'(MAX_DELAY) : wr_delay_i;
  // A new error event takes priority over a clear in the same cycle
  assign err_d    = (wr_en_i && (wr_oor || wr_clamp)) ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
  assign fill_d   = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + FW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q   <= {(NCHAN*(DEPTH-1)*NSAMP){MID}};
      beams_q  <= {(NBEAMS*NCHAN*NSAMP){MID}};
      shadow_q <= '0;
      active_q <= '0;
      fill_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        hist_q[c][0] <= data_i[c];
        for (int h = 1; h < DEPTH-1; h++) hist_q[c][h] <= hist_q[c][h-1];
      end
      // Update copies the pre-write shadow, so a same-cycle write waits for the next update
      if (wr_en_i && !wr_oor) shadow_q[wr_beam_i][wr_chan_i] <= wr_val;
      if (update_i) active_q <= shadow_q;
      beams_q <= sel;
      fill_q  <= fill_d;
      ack_q   <= update_i;
      err_q   <= err_d;
    end
  end

  assign beams_o      = beams_q;
  assign valid_o      = (fill_q == FW'(DEPTH));
  assign update_ack_o = ack_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_beam_delay_align_rt.sv
// Directed bench for beam_delay_align_rt: default build (8ch/8samp/2 beams) and a 4ch/4samp/3 beam build.
module tb_beam_delay_align_rt;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0][39:0]       d1;
  logic                   wen1, upd1, clr1;
  logic [0:0]             wb1;
  logic [2:0]             wc1;
  logic [6:0]             wd1;
  logic [1:0][7:0][39:0]  bo1;
  logic                   val1, ack1, err1;

  logic [3:0][19:0]       d2;
  logic                   wen2, upd2, clr2;
  logic [1:0]             wb2, wc2;
  logic [6:0]             wd2;
  logic [2:0][3:0][19:0]  bo2;
  logic                   val2, ack2, err2;

  beam_delay_align_rt dut1 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(d1), .wr_en_i(wen1), .wr_beam_i(wb1),
    .wr_chan_i(wc1), .wr_delay_i(wd1), .update_i(upd1), .err_clr_i(clr1),
    .beams_o(bo1), .valid_o(val1), .update_ack_o(ack1), .err_o(err1));

  beam_delay_align_rt #(.NCHAN(4), .NSAMP(4), .NBEAMS(3)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(d2), .wr_en_i(wen2), .wr_beam_i(wb2),
    .wr_chan_i(wc2), .wr_delay_i(wd2), .update_i(upd2), .err_clr_i(clr2),
    .beams_o(bo2), .valid_o(val2), .update_ack_o(ack2), .err_o(err2));

  int total = 0;
  int bad = 0;
  int k = 0;
  int a1[2][8];
  int a2[3][4];

  // Ramp x_c[n] = (n + 4c) mod 32; samples before reset release read midscale 16
  function automatic logic [39:0] ev1(input int c, input int d, input int e);
    logic [39:0] v;
    for (int s = 0; s < 8; s++) begin
      int n;
      n = 8*e + s - d;
      v[s*5 +: 5] = (n < 0) ? 5'd16 : 5'((n + 4*c) % 32);
    end
    return v;
  endfunction

  function automatic logic [19:0] ev2(input int c, input int d, input int e);
    logic [19:0] v;
    for (int s = 0; s < 4; s++) begin
      int n;
      n = 4*e + s - d;
      v[s*5 +: 5] = (n < 0) ? 5'd16 : 5'((n + 4*c) % 32);
    end
    return v;
  endfunction

  task automatic drive();
    for (int c = 0; c < 8; c++)
      for (int s = 0; s < 8; s++) d1[c][s*5 +: 5] = 5'((8*k + s + 4*c) % 32);
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < 4; s++) d2[c][s*5 +: 5] = 5'((4*k + s + 4*c) % 32);
  endtask

  // After tick() the outputs reflect edge index k-1
  task automatic tick();
    @(posedge clk); #1;
    k++;
    drive();
  endtask

  task automatic wr1(input int b, input int c, input int d);
    wen1 = 1'b1; wb1 = 1'(b); wc1 = 3'(c); wd1 = 7'(d);
    tick();
    wen1 = 1'b0;
  endtask

  task automatic wr2(input int b, input int c, input int d);
    wen2 = 1'b1; wb2 = 2'(b); wc2 = 2'(c); wd2 = 7'(d);
    tick();
    wen2 = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0][7:0][39:0] m1;
    logic [2:0][3:0][19:0] m2;
    m1 = {128{5'd16}};
    m2 = {48{5'd16}};
    rst_n = 1'b0; k = 0; drive();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bo1 !== m1) begin bad++; $display("FAIL reset_beams1 got %h want %h", bo1, m1); end
    total++; if (bo2 !== m2) begin bad++; $display("FAIL reset_beams2 got %h want %h", bo2, m2); end
    total++; if ({val1, ack1, err1} !== 3'b000) begin bad++; $display("FAIL reset_flags1 got %b want 000", {val1, ack1, err1}); end
    total++; if ({val2, ack2, err2} !== 3'b000) begin bad++; $display("FAIL reset_flags2 got %b want 000", {val2, ack2, err2}); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    repeat (12) begin
      tick();
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 8; c++) begin
          total++;
          if (bo1[b][c] !== ev1(c, a1[b][c], k-1)) begin
            bad++; $display("FAIL ramp1 b%0d c%0d e%0d got %h want %h", b, c, k-1, bo1[b][c], ev1(c, a1[b][c], k-1));
          end
        end
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < 4; c++) begin
          total++;
          if (bo2[b][c] !== ev2(c, a2[b][c], k-1)) begin
            bad++; $display("FAIL ramp2 b%0d c%0d e%0d got %h want %h", b, c, k-1, bo2[b][c], ev2(c, a2[b][c], k-1));
          end
        end
      total++; if (val1 !== ((k-1) >= 9)) begin bad++; $display("FAIL valid1 e%0d got %b want %b", k-1, val1, (k-1) >= 9); end
      total++; if (val2 !== 1'b0) begin bad++; $display("FAIL valid2_early e%0d got %b want 0", k-1, val2); end
    end
  endtask

  task automatic test_delay_update();
    wr1(1, 3, 13);
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL wr13_err got %b want 0", err1); end
    upd1 = 1'b1; tick(); upd1 = 1'b0;
    total++; if (ack1 !== 1'b1) begin bad++; $display("FAIL upd_ack got %b want 1", ack1); end
    total++; if (bo1[1][3] !== ev1(3, 0, k-1)) begin bad++; $display("FAIL upd_old got %h want %h", bo1[1][3], ev1(3, 0, k-1)); end
    a1[1][3] = 13;
    repeat (2) begin
      tick();
      total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL upd_ack_low got %b want 0", ack1); end
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 8; c++) begin
          total++;
          if (bo1[b][c] !== ev1(c, a1[b][c], k-1)) begin
            bad++; $display("FAIL d13 b%0d c%0d got %h want %h", b, c, bo1[b][c], ev1(c, a1[b][c], k-1));
          end
        end
    end
  endtask

  task automatic test_clamp_err();
    wr1(0, 0, 72);
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL max_no_err got %b want 0", err1); end
    wr1(0, 7, 100);
    total++; if (err1 !== 1'b1) begin bad++; $display("FAIL clamp_err got %b want 1", err1); end
    upd1 = 1'b1; tick(); upd1 = 1'b0;
    a1[0][0] = 72; a1[0][7] = 72;
    tick();
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 8; c++) begin
        total++;
        if (bo1[b][c] !== ev1(c, a1[b][c], k-1)) begin
          bad++; $display("FAIL clamp b%0d c%0d got %h want %h", b, c, bo1[b][c], ev1(c, a1[b][c], k-1));
        end
      end
    total++; if (err1 !== 1'b1) begin bad++; $display("FAIL err_sticky got %b want 1", err1); end
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL err_clr got %b want 0", err1); end
    clr1 = 1'b1; wr1(0, 7, 100); clr1 = 1'b0;
    total++; if (err1 !== 1'b1) begin bad++; $display("FAIL err_vs_clr got %b want 1", err1); end
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL err_clr2 got %b want 0", err1); end
  endtask

  task automatic test_switch();
    wr1(0, 2, 5);
    upd1 = 1'b1; tick(); upd1 = 1'b0;
    a1[0][2] = 5;
    tick();
    total++; if (bo1[0][2] !== ev1(2, 5, k-1)) begin bad++; $display("FAIL sw5 got %h want %h", bo1[0][2], ev1(2, 5, k-1)); end
    wr1(0, 2, 6);
    upd1 = 1'b1; tick(); upd1 = 1'b0;
    total++; if (bo1[0][2] !== ev1(2, 5, k-1)) begin bad++; $display("FAIL sw_last5 got %h want %h", bo1[0][2], ev1(2, 5, k-1)); end
    a1[0][2] = 6;
    tick();
    total++; if (bo1[0][2] !== ev1(2, 6, k-1)) begin bad++; $display("FAIL sw_first6 got %h want %h", bo1[0][2], ev1(2, 6, k-1)); end
  endtask

  task automatic test_same_cycle();
    upd1 = 1'b1; wr1(1, 0, 9); upd1 = 1'b0;
    total++; if (ack1 !== 1'b1) begin bad++; $display("FAIL same_ack got %b want 1", ack1); end
    tick();
    total++; if (bo1[1][0] !== ev1(0, 0, k-1)) begin bad++; $display("FAIL same_old got %h want %h", bo1[1][0], ev1(0, 0, k-1)); end
    upd1 = 1'b1; tick(); upd1 = 1'b0;
    a1[1][0] = 9;
    tick();
    total++; if (bo1[1][0] !== ev1(0, 9, k-1)) begin bad++; $display("FAIL same_new got %h want %h", bo1[1][0], ev1(0, 9, k-1)); end
  endtask

  task automatic test_hold_update();
    upd1 = 1'b1;
    repeat (3) begin
      tick();
      total++; if (ack1 !== 1'b1) begin bad++; $display("FAIL hold_ack got %b want 1", ack1); end
    end
    upd1 = 1'b0;
    tick();
    total++; if (ack1 !== 1'b0) begin bad++; $display("FAIL hold_release got %b want 0", ack1); end
  endtask

  task automatic test_dut2();
    wr2(3, 1, 5);
    total++; if (err2 !== 1'b1) begin bad++; $display("FAIL oor_err got %b want 1", err2); end
    wr2(2, 3, 9);
    upd2 = 1'b1; tick(); upd2 = 1'b0;
    total++; if (ack2 !== 1'b1) begin bad++; $display("FAIL ack2 got %b want 1", ack2); end
    a2[2][3] = 9;
    tick();
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < 4; c++) begin
        total++;
        if (bo2[b][c] !== ev2(c, a2[b][c], k-1)) begin
          bad++; $display("FAIL dut2 b%0d c%0d got %h want %h", b, c, bo2[b][c], ev2(c, a2[b][c], k-1));
        end
      end
    clr2 = 1'b1; tick(); clr2 = 1'b0;
    total++; if (err2 !== 1'b0) begin bad++; $display("FAIL err2_clr got %b want 0", err2); end
  endtask

  task automatic test_reset_mid();
    logic [1:0][7:0][39:0] m1;
    logic [2:0][3:0][19:0] m2;
    m1 = {128{5'd16}};
    m2 = {48{5'd16}};
    wr1(0, 5, 40);
    wr2(2, 3, 40);
    upd1 = 1'b1; upd2 = 1'b1; tick(); upd1 = 1'b0; upd2 = 1'b0;
    a1[0][5] = 40; a2[2][3] = 40;
    tick();
    total++; if (bo1[0][5] !== ev1(5, 40, k-1)) begin bad++; $display("FAIL d40 got %h want %h", bo1[0][5], ev1(5, 40, k-1)); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (bo1 !== m1) begin bad++; $display("FAIL midrst_beams1 got %h want %h", bo1, m1); end
    total++; if (bo2 !== m2) begin bad++; $display("FAIL midrst_beams2 got %h want %h", bo2, m2); end
    total++; if ({val1, val2} !== 2'b00) begin bad++; $display("FAIL midrst_valid got %b want 00", {val1, val2}); end
    foreach (a1[b, c]) a1[b][c] = 0;
    foreach (a2[b, c]) a2[b][c] = 0;
    k = 0; drive();
    @(negedge clk) rst_n = 1'b1;
    wr1(0, 5, 40);
    total++; if (bo1[0][5] !== ev1(5, 0, 0)) begin bad++; $display("FAIL midrst_tbl got %h want %h", bo1[0][5], ev1(5, 0, 0)); end
    upd1 = 1'b1; tick(); upd1 = 1'b0;
    a1[0][5] = 40;
    repeat (18) begin
      tick();
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 8; c++) begin
          total++;
          if (bo1[b][c] !== ev1(c, a1[b][c], k-1)) begin
            bad++; $display("FAIL refill1 b%0d c%0d e%0d got %h want %h", b, c, k-1, bo1[b][c], ev1(c, a1[b][c], k-1));
          end
        end
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < 4; c++) begin
          total++;
          if (bo2[b][c] !== ev2(c, a2[b][c], k-1)) begin
            bad++; $display("FAIL refill2 b%0d c%0d e%0d got %h want %h", b, c, k-1, bo2[b][c], ev2(c, a2[b][c], k-1));
          end
        end
      total++; if (val1 !== ((k-1) >= 9)) begin bad++; $display("FAIL refill_valid1 e%0d got %b want %b", k-1, val1, (k-1) >= 9); end
      total++; if (val2 !== ((k-1) >= 18)) begin bad++; $display("FAIL refill_valid2 e%0d got %b want %b", k-1, val2, (k-1) >= 18); end
    end
  endtask

  initial begin
    wen1 = 1'b0; upd1 = 1'b0; clr1 = 1'b0; wb1 = '0; wc1 = '0; wd1 = '0;
    wen2 = 1'b0; upd2 = 1'b0; clr2 = 1'b0; wb2 = '0; wc2 = '0; wd2 = '0;
    foreach (a1[b, c]) a1[b][c] = 0;
    foreach (a2[b, c]) a2[b][c] = 0;
    test_reset();
    test_ramp();
    test_delay_update();
    test_clamp_err();
    test_switch();
    test_same_cycle();
    test_hold_update();
    test_dut2();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
